ysyx_23060025_axi_arbiter: RTL and testbench
============================================

Name: ysyx_23060025_axi_arbiter

Overview:
- Two-master, one-slave AXI4-Lite-style arbiter placed directly downstream of the IFU and LSU memory ports.
- Serialises IFU instruction reads and LSU loads/stores onto the single memory/SoC AXI port.
- Allows exactly one transaction in flight.
- Channels are combinational pass-through once granted. Arbitration costs one IDLE cycle per transaction.

Parameters:
- DATA_LEN, 32, data bus width.
- ADDR_LEN, 32, address bus width.
- TIMEOUT, 255, maximum cycles a granted transaction may remain open before err_timeout_o sets.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ifu_addr_r_addr_i/size_i/valid_i  in  ADDR_LEN/3/1  IFU read-address channel.
- ifu_addr_r_ready_o  out  1  IFU AR ready.
- ifu_r_data_o/resp_o/valid_o  out  DATA_LEN/2/1  IFU read-data channel.
- ifu_r_ready_i  in  1  IFU R ready.
- lsu_addr_r_addr_i/size_i/valid_i  in  ADDR_LEN/3/1  LSU read-address channel.
- lsu_addr_r_ready_o  out  1  LSU AR ready.
- lsu_r_data_o/resp_o/valid_o  out  DATA_LEN/2/1  LSU read-data channel.
- lsu_r_ready_i  in  1  LSU R ready.
- lsu_addr_w_addr_i/size_i/valid_i  in  ADDR_LEN/3/1  LSU write-address channel.
- lsu_addr_w_ready_o  out  1  LSU AW ready.
- lsu_w_data_i/strb_i/valid_i  in  DATA_LEN/4/1  LSU write-data channel.
- lsu_w_ready_o  out  1  LSU W ready.
- lsu_bkwd_resp_o/valid_o  out  2/1  LSU write response.
- lsu_bkwd_ready_i  in  1  LSU B ready.
- mem_addr_r_addr_o/size_o/valid_o  out  ADDR_LEN/3/1  slave AR.
- mem_addr_r_ready_i  in  1  slave AR ready.
- mem_r_data_i/resp_i/valid_i  in  DATA_LEN/2/1  slave R.
- mem_r_ready_o  out  1  slave R ready.
- mem_addr_w_addr_o/size_o/valid_o  out  ADDR_LEN/3/1  slave AW.
- mem_addr_w_ready_i  in  1  slave AW ready.
- mem_w_data_o/strb_o/valid_o  out  DATA_LEN/4/1  slave W.
- mem_w_ready_i  in  1  slave W ready.
- mem_bkwd_resp_i/valid_i  in  2/1  slave B.
- mem_bkwd_ready_o  out  1  slave B ready.
- grant_o  out  2  current owner: 00 none, 01 IFU, 10 LSU read, 11 LSU write.
- err_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Clocking and reset: one clock, clock. Reset is synchronous and active-high (reset).
- Reset values: state IDLE, aw_done=0, w_done=0, watchdog=0, err_timeout_o=0, grant_o=00.
- While reset=1, every valid/ready output is forced to 0 in the same cycle, and every address/data/strb/size/resp output is 0.
- States: IDLE, IFU_R, LSU_R, LSU_W. grant_o encodes the state.
- IDLE arbitration, evaluated only in IDLE, with fixed priority:
  - (lsu_addr_w_valid_i | lsu_w_valid_i) -> LSU_W
  - else lsu_addr_r_valid_i -> LSU_R
  - else ifu_addr_r_valid_i -> IFU_R
  - else stay IDLE.
  - The transition takes effect at the next edge. In IDLE all mem_*valid and all master-side ready/valid outputs are 0.
- Granted state, pass-through:
  - The owner's request channels drive mem_* outputs combinationally.
  - mem ready and response signals route back to the owner only.
  - The non-owner sees all ready=0 and valid=0, and its data/resp outputs are 0.
  - mem outputs of unused channels are 0.
- IFU_R / LSU_R: return to IDLE on the edge where mem_r_valid_i & owner r_ready is high. r_data and r_resp are forwarded unmodified.
- LSU_W:
  - aw_done sets on the AW handshake; w_done sets on the W handshake. The two may complete in the same cycle or in either order.
  - mem_addr_w_valid_o = lsu_addr_w_valid_i & ~aw_done. mem_w_valid_o = lsu_w_valid_i & ~w_done.
  - mem_bkwd_ready_o = lsu_bkwd_ready_i & aw_done & w_done.
  - Return to IDLE on the B handshake; aw_done and w_done clear on that edge.
- A non-zero resp (SLVERR/DECERR) still ends the transaction and is forwarded unchanged.
- Throughput: there is no same-cycle regrant. Minimum spacing between two AR handshakes is 1 IDLE cycle plus the transaction cycles. A master held off keeps its valid high and sees ready=0. No starvation handling beyond fixed priority.
- Master drops valid in IDLE before being granted: no state change.
- Owner drops valid after grant but before handshake: the arbiter stays in the granted state until the response arrives, and the watchdog covers the hang.
- Watchdog:
  - Counts cycles in any non-IDLE state and clears in IDLE.
  - When the count reaches TIMEOUT, err_timeout_o sets and stays set until reset.
  - The transaction is not aborted.
  - The counter saturates and never wraps.
- Reset mid-transaction: outputs zero immediately, state becomes IDLE at the edge, and aw_done/w_done/watchdog clear. Any in-flight slave response after reset is ignored because ready=0.

Test Plan:
- IFU read only: ifu AR addr=0x8000_0000 at t0, slave arready at t2, rdata=0x0000_0413 at t4 -> grant_o=01 at t1, ifu_r_data_o=0x0000_0413 with valid at t4, IDLE at t5.
- Simultaneous IFU and LSU read requests at t0 -> LSU_R granted (grant_o=10). ifu_addr_r_ready_o=0 throughout the LSU read. IFU granted one cycle after the LSU R handshake.
- LSU store with W accepted 2 cycles before AW: addr=0x0F00_0004, strb=4'b1100 -> mem_w_valid_o drops after the W handshake, and mem_bkwd_ready_o rises only after the AW handshake. bkwd_resp=00 returns to the LSU.
- LSU read with mem_r_resp_i=2'b10 -> lsu_r_resp_o=2'b10 and the transaction ends normally.
- Slave never asserts rvalid, TIMEOUT=8 -> err_timeout_o=1 at 8 granted cycles and stays 1. Reset -> err_timeout_o=0, grant_o=00, all valid outputs 0 in the reset cycle.

Source files
------------

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter that serialises IFU reads and LSU loads/stores.
// One transaction is in flight at a time, and the granted channels pass straight through.
module ysyx_23060025_axi_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_LEN-1:0]   ifu_addr_r_addr_i,
    input  logic [2:0]            ifu_addr_r_size_i,
    input  logic                  ifu_addr_r_valid_i,
    output logic                  ifu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]   ifu_r_data_o,
    output logic [1:0]            ifu_r_resp_o,
    output logic                  ifu_r_valid_o,
    input  logic                  ifu_r_ready_i,

    input  logic [ADDR_LEN-1:0]   lsu_addr_r_addr_i,
    input  logic [2:0]            lsu_addr_r_size_i,
    input  logic                  lsu_addr_r_valid_i,
    output logic                  lsu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]   lsu_r_data_o,
    output logic [1:0]            lsu_r_resp_o,
    output logic                  lsu_r_valid_o,
    input  logic                  lsu_r_ready_i,

    input  logic [ADDR_LEN-1:0]   lsu_addr_w_addr_i,
    input  logic [2:0]            lsu_addr_w_size_i,
    input  logic                  lsu_addr_w_valid_i,
    output logic                  lsu_addr_w_ready_o,
    input  logic [DATA_LEN-1:0]   lsu_w_data_i,
    input  logic [3:0]            lsu_w_strb_i,
    input  logic                  lsu_w_valid_i,
    output logic                  lsu_w_ready_o,
    output logic [1:0]            lsu_bkwd_resp_o,
    output logic                  lsu_bkwd_valid_o,
    input  logic                  lsu_bkwd_ready_i,

    output logic [ADDR_LEN-1:0]   mem_addr_r_addr_o,
    output logic [2:0]            mem_addr_r_size_o,
    output logic                  mem_addr_r_valid_o,
    input  logic                  mem_addr_r_ready_i,
    input  logic [DATA_LEN-1:0]   mem_r_data_i,
    input  logic [1:0]            mem_r_resp_i,
    input  logic                  mem_r_valid_i,
    output logic                  mem_r_ready_o,

    output logic [ADDR_LEN-1:0]   mem_addr_w_addr_o,
    output logic [2:0]            mem_addr_w_size_o,
    output logic                  mem_addr_w_valid_o,
    input  logic                  mem_addr_w_ready_i,
    output logic [DATA_LEN-1:0]   mem_w_data_o,
    output logic [3:0]            mem_w_strb_o,
    output logic                  mem_w_valid_o,
    input  logic                  mem_w_ready_i,
    input  logic [1:0]            mem_bkwd_resp_i,
    input  logic                  mem_bkwd_valid_i,
    output logic                  mem_bkwd_ready_o,

    output logic [1:0]            grant_o,
    output logic                  err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IFU_R = 2'b01,
        LSU_R = 2'b10,
        LSU_W = 2'b11
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t          state, state_nxt;
    logic            aw_done, w_done;
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            aw_hs, w_hs, b_hs;

    assign aw_hs = mem_addr_w_valid_o & mem_addr_w_ready_i;
    assign w_hs  = mem_w_valid_o & mem_w_ready_i;
    assign b_hs  = mem_bkwd_valid_i & mem_bkwd_ready_o;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wd_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (b_hs) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            // Saturating watchdog; the flag latches on the edge the count hits TIMEOUT.
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
                if (wd_cnt + WD_W'(1) == WD_MAX) err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu_addr_w_valid_i | lsu_w_valid_i) state_nxt = LSU_W;
                else if (lsu_addr_r_valid_i)            state_nxt = LSU_R;
                else if (ifu_addr_r_valid_i)            state_nxt = IFU_R;
            end
            IFU_R: if (mem_r_valid_i & ifu_r_ready_i) state_nxt = IDLE;
            LSU_R: if (mem_r_valid_i & lsu_r_ready_i) state_nxt = IDLE;
            LSU_W: if (mem_bkwd_valid_i & lsu_bkwd_ready_i & aw_done & w_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o       = reset ? 2'b00 : state;
    assign err_timeout_o = err_q & ~reset;

    always_comb begin
        ifu_addr_r_ready_o = 1'b0;
        ifu_r_data_o       = '0;
        ifu_r_resp_o       = 2'b00;
        ifu_r_valid_o      = 1'b0;
        lsu_addr_r_ready_o = 1'b0;
        lsu_r_data_o       = '0;
        lsu_r_resp_o       = 2'b00;
        lsu_r_valid_o      = 1'b0;
        lsu_addr_w_ready_o = 1'b0;
        lsu_w_ready_o      = 1'b0;
        lsu_bkwd_resp_o    = 2'b00;
        lsu_bkwd_valid_o   = 1'b0;
        mem_addr_r_addr_o  = '0;
        mem_addr_r_size_o  = 3'b000;
        mem_addr_r_valid_o = 1'b0;
        mem_r_ready_o      = 1'b0;
        mem_addr_w_addr_o  = '0;
        mem_addr_w_size_o  = 3'b000;
        mem_addr_w_valid_o = 1'b0;
        mem_w_data_o       = '0;
        mem_w_strb_o       = 4'b0000;
        mem_w_valid_o      = 1'b0;
        mem_bkwd_ready_o   = 1'b0;
        if (!reset) begin
            case (state)
                IFU_R: begin
                    mem_addr_r_addr_o  = ifu_addr_r_addr_i;
                    mem_addr_r_size_o  = ifu_addr_r_size_i;
                    mem_addr_r_valid_o = ifu_addr_r_valid_i;
                    ifu_addr_r_ready_o = mem_addr_r_ready_i;
                    ifu_r_data_o       = mem_r_data_i;
                    ifu_r_resp_o       = mem_r_resp_i;
                    ifu_r_valid_o      = mem_r_valid_i;
                    mem_r_ready_o      = ifu_r_ready_i;
                end
                LSU_R: begin
                    mem_addr_r_addr_o  = lsu_addr_r_addr_i;
                    mem_addr_r_size_o  = lsu_addr_r_size_i;
                    mem_addr_r_valid_o = lsu_addr_r_valid_i;
                    lsu_addr_r_ready_o = mem_addr_r_ready_i;
                    lsu_r_data_o       = mem_r_data_i;
                    lsu_r_resp_o       = mem_r_resp_i;
                    lsu_r_valid_o      = mem_r_valid_i;
                    mem_r_ready_o      = lsu_r_ready_i;
                end
                LSU_W: begin
                    // AW and W each complete once; the B channel opens only after both.
                    mem_addr_w_addr_o  = lsu_addr_w_addr_i;
                    mem_addr_w_size_o  = lsu_addr_w_size_i;
                    mem_addr_w_valid_o = lsu_addr_w_valid_i & ~aw_done;
                    lsu_addr_w_ready_o = mem_addr_w_ready_i & ~aw_done;
                    mem_w_data_o       = lsu_w_data_i;
                    mem_w_strb_o       = lsu_w_strb_i;
                    mem_w_valid_o      = lsu_w_valid_i & ~w_done;
                    lsu_w_ready_o      = mem_w_ready_i & ~w_done;
                    lsu_bkwd_resp_o    = mem_bkwd_resp_i;
                    lsu_bkwd_valid_o   = mem_bkwd_valid_i & aw_done & w_done;
                    mem_bkwd_ready_o   = lsu_bkwd_ready_i & aw_done & w_done;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter with a short watchdog timeout.
module tb_ysyx_23060025_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] ifu_addr_r_addr_i = '0;
    logic [2:0]  ifu_addr_r_size_i = '0;
    logic        ifu_addr_r_valid_i = 1'b0;
    logic        ifu_addr_r_ready_o;
    logic [31:0] ifu_r_data_o;
    logic [1:0]  ifu_r_resp_o;
    logic        ifu_r_valid_o;
    logic        ifu_r_ready_i = 1'b0;

    logic [31:0] lsu_addr_r_addr_i = '0;
    logic [2:0]  lsu_addr_r_size_i = '0;
    logic        lsu_addr_r_valid_i = 1'b0;
    logic        lsu_addr_r_ready_o;
    logic [31:0] lsu_r_data_o;
    logic [1:0]  lsu_r_resp_o;
    logic        lsu_r_valid_o;
    logic        lsu_r_ready_i = 1'b0;

    logic [31:0] lsu_addr_w_addr_i = '0;
    logic [2:0]  lsu_addr_w_size_i = '0;
    logic        lsu_addr_w_valid_i = 1'b0;
    logic        lsu_addr_w_ready_o;
    logic [31:0] lsu_w_data_i = '0;
    logic [3:0]  lsu_w_strb_i = '0;
    logic        lsu_w_valid_i = 1'b0;
    logic        lsu_w_ready_o;
    logic [1:0]  lsu_bkwd_resp_o;
    logic        lsu_bkwd_valid_o;
    logic        lsu_bkwd_ready_i = 1'b0;

    logic [31:0] mem_addr_r_addr_o;
    logic [2:0]  mem_addr_r_size_o;
    logic        mem_addr_r_valid_o;
    logic        mem_addr_r_ready_i = 1'b0;
    logic [31:0] mem_r_data_i = '0;
    logic [1:0]  mem_r_resp_i = '0;
    logic        mem_r_valid_i = 1'b0;
    logic        mem_r_ready_o;

    logic [31:0] mem_addr_w_addr_o;
    logic [2:0]  mem_addr_w_size_o;
    logic        mem_addr_w_valid_o;
    logic        mem_addr_w_ready_i = 1'b0;
    logic [31:0] mem_w_data_o;
    logic [3:0]  mem_w_strb_o;
    logic        mem_w_valid_o;
    logic        mem_w_ready_i = 1'b0;
    logic [1:0]  mem_bkwd_resp_i = '0;
    logic        mem_bkwd_valid_i = 1'b0;
    logic        mem_bkwd_ready_o;

    logic [1:0]  grant_o;
    logic        err_timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .ifu_addr_r_addr_i(ifu_addr_r_addr_i), .ifu_addr_r_size_i(ifu_addr_r_size_i),
        .ifu_addr_r_valid_i(ifu_addr_r_valid_i), .ifu_addr_r_ready_o(ifu_addr_r_ready_o),
        .ifu_r_data_o(ifu_r_data_o), .ifu_r_resp_o(ifu_r_resp_o),
        .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i),
        .lsu_addr_r_addr_i(lsu_addr_r_addr_i), .lsu_addr_r_size_i(lsu_addr_r_size_i),
        .lsu_addr_r_valid_i(lsu_addr_r_valid_i), .lsu_addr_r_ready_o(lsu_addr_r_ready_o),
        .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o),
        .lsu_r_valid_o(lsu_r_valid_o), .lsu_r_ready_i(lsu_r_ready_i),
        .lsu_addr_w_addr_i(lsu_addr_w_addr_i), .lsu_addr_w_size_i(lsu_addr_w_size_i),
        .lsu_addr_w_valid_i(lsu_addr_w_valid_i), .lsu_addr_w_ready_o(lsu_addr_w_ready_o),
        .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i),
        .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_ready_o(lsu_w_ready_o),
        .lsu_bkwd_resp_o(lsu_bkwd_resp_o), .lsu_bkwd_valid_o(lsu_bkwd_valid_o),
        .lsu_bkwd_ready_i(lsu_bkwd_ready_i),
        .mem_addr_r_addr_o(mem_addr_r_addr_o), .mem_addr_r_size_o(mem_addr_r_size_o),
        .mem_addr_r_valid_o(mem_addr_r_valid_o), .mem_addr_r_ready_i(mem_addr_r_ready_i),
        .mem_r_data_i(mem_r_data_i), .mem_r_resp_i(mem_r_resp_i),
        .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
        .mem_addr_w_addr_o(mem_addr_w_addr_o), .mem_addr_w_size_o(mem_addr_w_size_o),
        .mem_addr_w_valid_o(mem_addr_w_valid_o), .mem_addr_w_ready_i(mem_addr_w_ready_i),
        .mem_w_data_o(mem_w_data_o), .mem_w_strb_o(mem_w_strb_o),
        .mem_w_valid_o(mem_w_valid_o), .mem_w_ready_i(mem_w_ready_i),
        .mem_bkwd_resp_i(mem_bkwd_resp_i), .mem_bkwd_valid_i(mem_bkwd_valid_i),
        .mem_bkwd_ready_o(mem_bkwd_ready_o),
        .grant_o(grant_o), .err_timeout_o(err_timeout_o)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a slave response pending: nothing may leak through.
        mem_r_valid_i = 1'b1;
        mem_addr_r_ready_i = 1'b1;
        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_err", err_timeout_o, 1'b0);
        chk("rst_mem_r_ready", mem_r_ready_o, 1'b0);
        chk("rst_ifu_r_valid", ifu_r_valid_o, 1'b0);
        step();
        step();
        reset = 1'b0;
        mem_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;

        // IFU read only
        ifu_addr_r_addr_i = 32'h8000_0000;
        ifu_addr_r_size_i = 3'd2;
        ifu_addr_r_valid_i = 1'b1;
        #1;
        chk("t1_idle_grant", grant_o, 2'b00);
        chk("t1_idle_arvalid", mem_addr_r_valid_o, 1'b0);
        step();
        #1;
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_araddr", mem_addr_r_addr_o, 32'h8000_0000);
        chk("t1_arvalid", mem_addr_r_valid_o, 1'b1);
        chk("t1_arready_lo", ifu_addr_r_ready_o, 1'b0);
        step();
        mem_addr_r_ready_i = 1'b1;
        #1;
        chk("t1_arready_hi", ifu_addr_r_ready_o, 1'b1);
        step();
        ifu_addr_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;
        ifu_r_ready_i = 1'b1;
        step();
        mem_r_data_i = 32'h0000_0413;
        mem_r_resp_i = 2'b00;
        mem_r_valid_i = 1'b1;
        #1;
        chk("t1_rdata", ifu_r_data_o, 32'h0000_0413);
        chk("t1_rvalid", ifu_r_valid_o, 1'b1);
        chk("t1_rready", mem_r_ready_o, 1'b1);
        chk("t1_lsu_rvalid", lsu_r_valid_o, 1'b0);
        step();
        mem_r_valid_i = 1'b0;
        #1;
        chk("t1_back_idle", grant_o, 2'b00);

        // Simultaneous IFU and LSU reads: LSU wins
        ifu_addr_r_addr_i = 32'h8000_0004;
        ifu_addr_r_valid_i = 1'b1;
        lsu_addr_r_addr_i = 32'h0000_1000;
        lsu_addr_r_valid_i = 1'b1;
        lsu_r_ready_i = 1'b1;
        step();
        #1;
        chk("t2_grant_lsu", grant_o, 2'b10);
        chk("t2_araddr", mem_addr_r_addr_o, 32'h0000_1000);
        mem_addr_r_ready_i = 1'b1;
        #1;
        chk("t2_lsu_arready", lsu_addr_r_ready_o, 1'b1);
        chk("t2_ifu_arready", ifu_addr_r_ready_o, 1'b0);
        step();
        lsu_addr_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;
        mem_r_data_i = 32'h0000_CAFE;
        mem_r_valid_i = 1'b1;
        #1;
        chk("t2_lsu_rdata", lsu_r_data_o, 32'h0000_CAFE);
        chk("t2_lsu_rvalid", lsu_r_valid_o, 1'b1);
        chk("t2_ifu_rvalid", ifu_r_valid_o, 1'b0);
        chk("t2_ifu_rdata", ifu_r_data_o, 32'h0);
        chk("t2_ifu_arready2", ifu_addr_r_ready_o, 1'b0);
        step();
        mem_r_valid_i = 1'b0;
        #1;
        chk("t2_idle_gap", grant_o, 2'b00);
        step();
        #1;
        chk("t2_grant_ifu", grant_o, 2'b01);
        chk("t2_ifu_araddr", mem_addr_r_addr_o, 32'h8000_0004);
        mem_addr_r_ready_i = 1'b1;
        step();
        ifu_addr_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;
        mem_r_data_i = 32'h1234_5678;
        mem_r_valid_i = 1'b1;
        #1;
        chk("t2_ifu_rdata2", ifu_r_data_o, 32'h1234_5678);
        step();
        mem_r_valid_i = 1'b0;
        #1;
        chk("t2_end_idle", grant_o, 2'b00);

        // LSU store, W accepted two cycles before AW
        lsu_addr_w_addr_i = 32'h0F00_0004;
        lsu_addr_w_size_i = 3'd2;
        lsu_addr_w_valid_i = 1'b1;
        lsu_w_data_i = 32'hAABB_0000;
        lsu_w_strb_i = 4'b1100;
        lsu_w_valid_i = 1'b1;
        lsu_bkwd_ready_i = 1'b1;
        step();
        #1;
        chk("t3_grant", grant_o, 2'b11);
        chk("t3_awaddr", mem_addr_w_addr_o, 32'h0F00_0004);
        chk("t3_wstrb", mem_w_strb_o, 4'b1100);
        chk("t3_wdata", mem_w_data_o, 32'hAABB_0000);
        chk("t3_wvalid", mem_w_valid_o, 1'b1);
        mem_w_ready_i = 1'b1;
        #1;
        chk("t3_wready", lsu_w_ready_o, 1'b1);
        step();
        mem_w_ready_i = 1'b0;
        #1;
        chk("t3_wvalid_drop", mem_w_valid_o, 1'b0);
        chk("t3_awvalid_held", mem_addr_w_valid_o, 1'b1);
        chk("t3_bready_lo1", mem_bkwd_ready_o, 1'b0);
        step();
        lsu_w_valid_i = 1'b0;
        mem_addr_w_ready_i = 1'b1;
        #1;
        chk("t3_awready", lsu_addr_w_ready_o, 1'b1);
        chk("t3_bready_lo2", mem_bkwd_ready_o, 1'b0);
        step();
        lsu_addr_w_valid_i = 1'b0;
        mem_addr_w_ready_i = 1'b0;
        #1;
        chk("t3_bready_hi", mem_bkwd_ready_o, 1'b1);
        chk("t3_awvalid_drop", mem_addr_w_valid_o, 1'b0);
        mem_bkwd_resp_i = 2'b00;
        mem_bkwd_valid_i = 1'b1;
        #1;
        chk("t3_bvalid", lsu_bkwd_valid_o, 1'b1);
        chk("t3_bresp", lsu_bkwd_resp_o, 2'b00);
        step();
        mem_bkwd_valid_i = 1'b0;
        lsu_bkwd_ready_i = 1'b0;
        #1;
        chk("t3_idle", grant_o, 2'b00);
        chk("t3_bready_idle", mem_bkwd_ready_o, 1'b0);

        // LSU read returning SLVERR
        lsu_addr_r_addr_i = 32'h0000_2000;
        lsu_addr_r_valid_i = 1'b1;
        step();
        #1;
        chk("t4_grant", grant_o, 2'b10);
        mem_addr_r_ready_i = 1'b1;
        step();
        lsu_addr_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;
        mem_r_data_i = 32'h0;
        mem_r_resp_i = 2'b10;
        mem_r_valid_i = 1'b1;
        #1;
        chk("t4_rresp", lsu_r_resp_o, 2'b10);
        step();
        mem_r_valid_i = 1'b0;
        mem_r_resp_i = 2'b00;
        #1;
        chk("t4_idle", grant_o, 2'b00);
        chk("t4_no_err", err_timeout_o, 1'b0);

        // Slave never returns data: watchdog fires after 8 granted cycles
        lsu_addr_r_addr_i = 32'h0000_3000;
        lsu_addr_r_valid_i = 1'b1;
        step();
        mem_addr_r_ready_i = 1'b1;
        #1;
        chk("t5_grant", grant_o, 2'b10);
        step();
        lsu_addr_r_valid_i = 1'b0;
        mem_addr_r_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        #1;
        chk("t5_err_before", err_timeout_o, 1'b0);
        step();
        #1;
        chk("t5_err_set", err_timeout_o, 1'b1);
        chk("t5_still_granted", grant_o, 2'b10);
        step();
        step();
        #1;
        chk("t5_err_sticky", err_timeout_o, 1'b1);

        // Reset mid-transaction with a late response pending
        reset = 1'b1;
        mem_r_valid_i = 1'b1;
        #1;
        chk("t5_rst_err", err_timeout_o, 1'b0);
        chk("t5_rst_grant", grant_o, 2'b00);
        chk("t5_rst_lsu_rvalid", lsu_r_valid_o, 1'b0);
        chk("t5_rst_rready", mem_r_ready_o, 1'b0);
        step();
        reset = 1'b0;
        mem_r_valid_i = 1'b0;
        lsu_r_ready_i = 1'b0;
        ifu_r_ready_i = 1'b0;
        #1;
        chk("t5_post_grant", grant_o, 2'b00);
        chk("t5_post_err", err_timeout_o, 1'b0);
        step();
        #1;
        chk("t5_post_idle", grant_o, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
